// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and baud divisor helper.
// Imported by uart_rx and the tx path so both agree on bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Integer truncation: the bit period runs slightly short, which centred sampling tolerates.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VAL presets both flops so an idle line causes no spurious edge after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready holding register,
// one-cycle framing-error and overrun pulses.
//
// state    | meaning
// IDLE     | line idle, waiting for rx_s low
// START    | timing to middle of start bit, rejects glitches
// DATA     | sampling DATA_W bits, LSB first, one per bit period
// STOP     | sampling stop bit; high delivers byte, low flags error
// BREAK    | line held low after framing error, wait for release
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              t_valid_o,
  input  logic              t_ready_i,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              byte_done;
  logic              stop_bad;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      t_valid_o   <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_o <= stop_bad;
      overrun_o   <= byte_done & t_valid_o & ~t_ready_i;
      // A same-cycle accept frees the holding register for the new byte.
      if (byte_done && (!t_valid_o || t_ready_i)) begin
        data_o    <= shift_q;
        t_valid_o <= 1'b1;
      end else if (t_ready_i) begin
        t_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; a behavioural line
// driver and a queue-based reference of sent bytes check delivery and flags.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       t_ready_i = 1'b0;
  logic [7:0] data_o;
  logic       t_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .t_valid_o   (t_valid_o),
    .t_ready_i   (t_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // Event recorder: accepted bytes, flag pulses, handshake stability violations.
  logic [7:0] acc_q[$];
  int n_ferr = 0, n_ovr = 0, n_valid_cyc = 0, n_busy_cyc = 0, n_unstable = 0, n_both = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (t_valid_o && t_ready_i && !rst) acc_q.push_back(data_o);
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    if (t_valid_o) n_valid_cyc++;
    if (busy_o) n_busy_cyc++;
    if (frame_err_o && overrun_o) n_both++;
    if (prev_valid && !prev_ready && !prev_rst && (t_valid_o !== 1'b1 || data_o !== prev_data))
      n_unstable++;
    prev_valid = t_valid_o;
    prev_ready = t_ready_i;
    prev_rst   = rst;
    prev_data  = data_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = stop_val;
    tick(CPB);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_i = 1'b1; t_ready_i = 1'b0;
    tick(3);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
    checks++; if (t_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", t_valid_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int a0 = acc_q.size(), f0 = n_ferr, o0 = n_ovr, v0 = n_valid_cyc;
    int lat = -1;
    t_ready_i = 1'b1;
    fork
      send_byte(8'hAC, 1'b1);
      begin
        for (int c = 1; c <= 400; c++) begin
          @(posedge clk); #2;
          if (t_valid_o) begin lat = c; break; end
        end
      end
    join
    tick(CPB);
    // start edge -> valid: 2 sync + HALF + 9 bit periods + 1 delivery cycle
    checks++; if (lat < 2 + HALF + 9*CPB || lat > 2 + HALF + 9*CPB + 2)
      begin errors++; $display("FAIL single_latency got %0d want %0d+/-1", lat, 2 + HALF + 9*CPB + 1); end
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL single_count got %0d want 1", acc_q.size() - a0); end
    else begin
      checks++; if (acc_q[a0] !== 8'hAC) begin errors++; $display("FAIL single_data got %h want ac", acc_q[a0]); end
    end
    checks++; if (n_valid_cyc - v0 !== 1) begin errors++; $display("FAIL single_valid_width got %0d want 1", n_valid_cyc - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_ferr got %0d want 0", n_ferr - f0); end
    checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL single_ovr got %0d want 0", n_ovr - o0); end
  endtask

  task automatic test_back_to_back();
    int a0 = acc_q.size(), f0 = n_ferr, o0 = n_ovr, u0 = n_unstable;
    t_ready_i = 1'b0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    tick(4);
    checks++; if (t_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", t_valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL b2b_held_data got %h want 00", data_o); end
    checks++; if (n_ovr - o0 !== 2) begin errors++; $display("FAIL b2b_overruns got %0d want 2", n_ovr - o0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", n_ferr - f0); end
    checks++; if (n_unstable - u0 !== 0) begin errors++; $display("FAIL b2b_stable got %0d want 0", n_unstable - u0); end
    t_ready_i = 1'b1;
    tick(1);
    t_ready_i = 1'b0;
    tick(2);
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL b2b_count got %0d want 1", acc_q.size() - a0); end
    else begin
      checks++; if (acc_q[a0] !== 8'h00) begin errors++; $display("FAIL b2b_data got %h want 00", acc_q[a0]); end
    end
    checks++; if (t_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", t_valid_o); end
  endtask

  task automatic test_frame_err();
    int a0 = acc_q.size(), f0 = n_ferr, o0 = n_ovr;
    t_ready_i = 1'b1;
    send_byte(8'h3C, 1'b0);
    rx_i = 1'b0;
    tick(20*CPB);
    rx_i = 1'b1;
    tick(2*CPB);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", n_ferr - f0); end
    checks++; if (acc_q.size() - a0 !== 0) begin errors++; $display("FAIL ferr_no_valid got %0d want 0", acc_q.size() - a0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ferr_idle got %b want 0", busy_o); end
    send_byte(8'h3C, 1'b1);
    tick(CPB);
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL ferr_recover_count got %0d want 1", acc_q.size() - a0); end
    else begin
      checks++; if (acc_q[a0] !== 8'h3C) begin errors++; $display("FAIL ferr_recover_data got %h want 3c", acc_q[a0]); end
    end
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_total got %0d want 1", n_ferr - f0); end
    checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL ferr_ovr got %0d want 0", n_ovr - o0); end
  endtask

  task automatic test_glitch();
    int a0 = acc_q.size(), f0 = n_ferr, b0 = n_busy_cyc;
    t_ready_i = 1'b1;
    rx_i = 1'b0;
    tick(CPB/4);
    rx_i = 1'b1;
    tick(2*CPB);
    checks++; if (n_busy_cyc - b0 <= 0) begin errors++; $display("FAIL glitch_start_seen got %0d want >0", n_busy_cyc - b0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", busy_o); end
    checks++; if (acc_q.size() - a0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", acc_q.size() - a0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_reset_mid();
    int a0 = acc_q.size(), f0, o0;
    t_ready_i = 1'b0;
    send_byte(8'h96, 1'b1);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin rx_i = 1'b1; tick(CPB); end
    tick(HALF);
    f0 = n_ferr; o0 = n_ovr;
    rst = 1'b1;
    tick(1);
    checks++; if (t_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", t_valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    rst = 1'b0;
    t_ready_i = 1'b1;
    tick(CPB);
    send_byte(8'hA5, 1'b1);
    tick(CPB);
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", acc_q.size() - a0); end
    else begin
      checks++; if (acc_q[a0] !== 8'hA5) begin errors++; $display("FAIL rstmid_data_after got %h want a5", acc_q[a0]); end
    end
    checks++; if (n_ferr - f0 !== 0 || n_ovr - o0 !== 0)
      begin errors++; $display("FAIL rstmid_flags got ferr %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0); end
  endtask

  task automatic test_random_loopback();
    logic [7:0] exp_q[$];
    int a0 = acc_q.size(), f0 = n_ferr, o0 = n_ovr, u0 = n_unstable, x0 = n_both;
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 48; k++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          send_byte(b, 1'b1);
          rx_i = 1'b1;
          tick($urandom_range(0, 2*CPB));
        end
        tick(CPB);
        done = 1'b1;
      end
      begin
        while (!done) begin
          t_ready_i = 1'b0;
          tick($urandom_range(0, 6));
          t_ready_i = 1'b1;
          tick(1);
        end
      end
    join
    checks++; if (acc_q.size() - a0 !== exp_q.size())
      begin errors++; $display("FAIL rand_count got %0d want %0d", acc_q.size() - a0, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && a0 + k < acc_q.size(); k++) begin
      checks++; if (acc_q[a0 + k] !== exp_q[k])
        begin errors++; $display("FAIL rand_byte[%0d] got %h want %h", k, acc_q[a0 + k], exp_q[k]); end
    end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rand_ferr got %0d want 0", n_ferr - f0); end
    checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL rand_ovr got %0d want 0", n_ovr - o0); end
    checks++; if (n_unstable - u0 !== 0) begin errors++; $display("FAIL rand_stable got %0d want 0", n_unstable - u0); end
    checks++; if (n_both - x0 !== 0) begin errors++; $display("FAIL rand_flags_exclusive got %0d want 0", n_both - x0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random_loopback();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL flags_exclusive got %0d want 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
